// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Pipeline-wide widths, opcode constants and the writeback entry type
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int REG_ZERO  = 0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module  : commit_fifo
// Brief   : Synchronous FIFO, wrap-around pointers plus occupancy count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A pop does not make room for a same-cycle push: full blocks writes outright.
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_commit.sv
// ============================================================================
// Module  : writeback_commit
// Brief   : Queues MEM/WB results, writes the register file, owns the scoreboard
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_commit #(
  parameter  int DATA_W     = cpu_pkg::DATA_W,
  parameter  int NUM_REGS   = cpu_pkg::NUM_REGS,
  parameter  int FIFO_DEPTH = 4,
  parameter  int PEND_W     = 2,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic                wb_reg_write,
  input  logic                wb_mem_to_reg,
  input  logic [IDX_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]   wb_alu_result,
  input  logic [DATA_W-1:0]   wb_read_data,
  input  logic                rsv_valid,
  input  logic [IDX_W-1:0]    rsv_rd,
  output logic                rsv_ready,
  output logic                rf_req,
  input  logic                rf_gnt,
  output logic [IDX_W-1:0]    rf_index,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] valid_flags,
  output logic                err_underflow
);

  import cpu_pkg::*;

  localparam int ENTRY_W = IDX_W + DATA_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [IDX_W-1:0]  RZERO    = IDX_W'(REG_ZERO);

  logic                w_enq;
  logic                w_xfer;
  logic                w_rsv_fire;
  logic                w_underflow;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   w_wdata_sel;
  logic [ENTRY_W-1:0]  w_head;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [PEND_W-1:0]   r_pend [NUM_REGS];
  logic                r_err;

  assign wb_ready    = !w_fifo_full;
  assign w_wdata_sel = wb_mem_to_reg ? wb_read_data : wb_alu_result;
  assign w_enq       = wb_valid && wb_ready && wb_reg_write && (wb_rd != RZERO);

  commit_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_enq),
    .i_data  ({wb_rd, w_wdata_sel}),
    .i_pop   (w_xfer),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign rf_req               = !w_fifo_empty;
  assign {rf_index, rf_wdata} = w_head;
  assign w_xfer               = rf_req && rf_gnt;

  // A saturated counter can still take a reservation when it drains this cycle.
  assign rsv_ready  = !((r_pend[rsv_rd] == PEND_MAX) && !(w_xfer && (rf_index == rsv_rd)));
  assign w_rsv_fire = rsv_valid && rsv_ready && (rsv_rd != RZERO);
  assign w_underflow = w_xfer && (rf_index != RZERO) && (r_pend[rf_index] == '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_rsv_fire) w_inc[rsv_rd] = 1'b1;
    if (w_xfer)     w_dec[rf_index] = 1'b1;
    w_inc[0] = 1'b0;
    w_dec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
      if (w_underflow) r_err <= 1'b1;
    end
  end

  always_comb begin
    valid_flags = '1;
    for (int i = 1; i < NUM_REGS; i++) valid_flags[i] = (r_pend[i] == '0);
  end

  assign err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_writeback_commit.sv
// ============================================================================
// Module  : tb_writeback_commit
// Brief   : Directed vector table plus hand sequences for writeback_commit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_read_data;
  logic        rsv_valid, rsv_ready;
  logic [4:0]  rsv_rd;
  logic        rf_req, rf_gnt;
  logic [4:0]  rf_index;
  logic [31:0] rf_wdata;
  logic [31:0] valid_flags;
  logic        err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  writeback_commit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_rd         (wb_rd),
    .wb_alu_result (wb_alu_result),
    .wb_read_data  (wb_read_data),
    .rsv_valid     (rsv_valid),
    .rsv_rd        (rsv_rd),
    .rsv_ready     (rsv_ready),
    .rf_req        (rf_req),
    .rf_gnt        (rf_gnt),
    .rf_index      (rf_index),
    .rf_wdata      (rf_wdata),
    .valid_flags   (valid_flags),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic        wv, wr, m2r;
    logic [4:0]  rd;
    logic [31:0] alu, rdat;
    logic        rv;
    logic [4:0]  rrd;
    logic        gnt;
    logic        e_wbr, e_rsvr, e_req, chk_hd;
    logic [4:0]  e_idx;
    logic [31:0] e_dat, e_flags;
    logic        e_err;
  } vec_t;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  vec_t vecs [14];

  function automatic vec_t mk(logic wv, logic wr, logic m2r, logic [4:0] rd,
                              logic [31:0] alu, logic [31:0] rdat, logic rv,
                              logic [4:0] rrd, logic gnt, logic e_wbr, logic e_rsvr,
                              logic e_req, logic chk_hd, logic [4:0] e_idx,
                              logic [31:0] e_dat, logic [31:0] e_flags, logic e_err);
    vec_t v;
    v.wv = wv; v.wr = wr; v.m2r = m2r; v.rd = rd; v.alu = alu; v.rdat = rdat;
    v.rv = rv; v.rrd = rrd; v.gnt = gnt; v.e_wbr = e_wbr; v.e_rsvr = e_rsvr;
    v.e_req = e_req; v.chk_hd = chk_hd; v.e_idx = e_idx; v.e_dat = e_dat;
    v.e_flags = e_flags; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic wr, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic rv,
                       input logic [4:0] rrd, input logic gnt);
    @(negedge clk);
    wb_valid = wv; wb_reg_write = wr; wb_mem_to_reg = m2r; wb_rd = rd;
    wb_alu_result = alu; wb_read_data = rdat; rsv_valid = rv; rsv_rd = rrd; rf_gnt = gnt;
    #1;
  endtask

  task automatic idle(input logic gnt);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, gnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0; wb_rd = 0;
    wb_alu_result = 0; wb_read_data = 0; rsv_valid = 0; rsv_rd = 0; rf_gnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,0,1,5'd0,32'h0,        ALL1,        0);
    vecs[1]  = mk(0,0,0,5'd0,32'h0,32'h0,        1,5'd5,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[2]  = mk(1,1,0,5'd5,32'h1234,32'h0,     0,5'd0,1, 1,1,0,0,5'd0,32'h0,        32'hFFFF_FFDF,0);
    vecs[3]  = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,1,1,5'd5,32'h1234,     32'hFFFF_FFDF,0);
    vecs[4]  = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[5]  = mk(1,1,1,5'd7,32'h1,32'hDEADBEEF, 1,5'd7,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[6]  = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,1,1,5'd7,32'hDEADBEEF, 32'hFFFF_FF7F,0);
    vecs[7]  = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[8]  = mk(1,1,0,5'd0,32'h55,32'h0,       0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[9]  = mk(1,0,0,5'd4,32'h66,32'h0,       0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[10] = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[11] = mk(1,1,0,5'd9,32'h99,32'h0,       0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        0);
    vecs[12] = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,1,1,5'd9,32'h99,       ALL1,        0);
    vecs[13] = mk(0,0,0,5'd0,32'h0,32'h0,        0,5'd0,1, 1,1,0,0,5'd0,32'h0,        ALL1,        1);

    // Basic latency, load mux, dropped results and underflow
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wv, vecs[i].wr, vecs[i].m2r, vecs[i].rd, vecs[i].alu, vecs[i].rdat,
            vecs[i].rv, vecs[i].rrd, vecs[i].gnt);
      check($sformatf("v%0d wb_ready", i), 32'(wb_ready), 32'(vecs[i].e_wbr));
      check($sformatf("v%0d rsv_ready", i), 32'(rsv_ready), 32'(vecs[i].e_rsvr));
      check($sformatf("v%0d rf_req", i), 32'(rf_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d valid_flags", i), valid_flags, vecs[i].e_flags);
      check($sformatf("v%0d err_underflow", i), 32'(err_underflow), 32'(vecs[i].e_err));
      if (vecs[i].chk_hd) begin
        check($sformatf("v%0d rf_index", i), 32'(rf_index), 32'(vecs[i].e_idx));
        check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_dat);
      end
    end

    // Fill the queue with grant withheld, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 5'(i + 1), 32'hA0 + 32'(i), 32'h0, 0, 5'd0, 0);
      check("fill wb_ready", 32'(wb_ready), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 5'd6, 32'hBAD, 32'h0, 0, 5'd0, 0);
      check("full wb_ready", 32'(wb_ready), 32'd0);
      check("hold rf_req", 32'(rf_req), 32'd1);
      check("hold rf_index", 32'(rf_index), 32'd1);
      check("hold rf_wdata", rf_wdata, 32'hA0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("drain rf_req", 32'(rf_req), 32'd1);
      check("drain rf_index", 32'(rf_index), 32'(i + 1));
      check("drain rf_wdata", rf_wdata, 32'hA0 + 32'(i));
      check("drain wb_ready", 32'(wb_ready), (i == 0) ? 32'd0 : 32'd1);
    end
    idle(1);
    check("drained rf_req", 32'(rf_req), 32'd0);
    check("drained wb_ready", 32'(wb_ready), 32'd1);

    // Saturate r3, then reserve and commit r3 in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 0);
      check("sat rsv_ready", 32'(rsv_ready), 32'd1);
    end
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 0);
    check("max rsv_ready r3", 32'(rsv_ready), 32'd0);
    check("max flag r3", 32'(valid_flags[3]), 32'd0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd4, 0);
    check("other rsv_ready r4", 32'(rsv_ready), 32'd1);
    drive(1, 1, 0, 5'd3, 32'h33, 32'h0, 0, 5'd3, 0);
    check("enq rsv_ready r3", 32'(rsv_ready), 32'd0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 5'd3, 1);
    check("same rf_index", 32'(rf_index), 32'd3);
    check("same rsv_ready", 32'(rsv_ready), 32'd1);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd3, 1);
    check("net rsv_ready", 32'(rsv_ready), 32'd0);
    check("net flag r3", 32'(valid_flags[3]), 32'd0);
    check("net rf_req", 32'(rf_req), 32'd0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 5'd3, 32'h300 + 32'(i), 32'h0, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("count flag r3", 32'(valid_flags[3]), 32'd0);
    end
    idle(1);
    check("free flag r3", 32'(valid_flags[3]), 32'd1);
    check("sat err", 32'(err_underflow), 32'd0);

    // Asynchronous reset with two entries queued
    do_reset();
    drive(1, 1, 0, 5'd10, 32'h10, 32'h0, 1, 5'd10, 0);
    drive(1, 1, 0, 5'd11, 32'h11, 32'h0, 1, 5'd11, 0);
    idle(0);
    check("pre-rst rf_req", 32'(rf_req), 32'd1);
    check("pre-rst flags", valid_flags, 32'hFFFF_F3FF);
    #2 rst_n = 1'b0;
    #1;
    check("rst rf_req", 32'(rf_req), 32'd0);
    check("rst flags", valid_flags, ALL1);
    check("rst wb_ready", 32'(wb_ready), 32'd1);
    check("rst rf_index", 32'(rf_index), 32'd0);
    check("rst rf_wdata", rf_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("post-rst rf_req", 32'(rf_req), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
